// File: rtl/bip_control_unit.sv
// rtl/bip_control_unit.sv - BIP fetch/execute control: PC, instruction decode, halt.
// Optional BIP_ILLEGAL_TRAP_EN: undefined opcodes halt the core and raise o_illegal.
module bip_control_unit #(
  parameter int NB_DATA            = 16,
  parameter int NB_OPCODE          = 5,
  parameter int NB_OPERAND         = 11,
  parameter int LOG2_N_INSMEM_ADDR = 11
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [NB_DATA-1:0]            i_instruction,
  output logic [LOG2_N_INSMEM_ADDR-1:0] o_insmem_addr,
  output logic                          o_insmem_en,
  output logic [NB_OPERAND-1:0]         o_operand,
  output logic [1:0]                    o_sel_a,
  output logic                          o_sel_b,
  output logic                          o_op,
  output logic                          o_wr_acc,
  output logic                          o_wr_ram,
  output logic                          o_rd_ram,
  output logic                          o_halted
`ifdef BIP_ILLEGAL_TRAP_EN
  ,
  output logic                          o_illegal
`endif
);

  typedef enum logic [1:0] {
    S_FETCH = 2'b00,
    S_EXEC  = 2'b01,
    S_HALT  = 2'b10
  } state_t;

  localparam logic [NB_OPCODE-1:0] OP_HALT    = 5'd0;
  localparam logic [NB_OPCODE-1:0] OP_STORE   = 5'd1;
  localparam logic [NB_OPCODE-1:0] OP_LDV     = 5'd2;
  localparam logic [NB_OPCODE-1:0] OP_LDI     = 5'd3;
  localparam logic [NB_OPCODE-1:0] OP_ADDV    = 5'd4;
  localparam logic [NB_OPCODE-1:0] OP_ADDI    = 5'd5;
  localparam logic [NB_OPCODE-1:0] OP_SUBV    = 5'd6;
  localparam logic [NB_OPCODE-1:0] OP_SUBI    = 5'd7;

  state_t                          state_q, state_d;
  logic [LOG2_N_INSMEM_ADDR-1:0]   pc_q, pc_d;
  logic [NB_OPCODE-1:0]            opcode;

  assign opcode        = i_instruction[NB_DATA-1 -: NB_OPCODE];
  assign o_operand     = i_instruction[NB_OPERAND-1:0];
  assign o_insmem_addr = pc_q;
  assign o_halted      = (state_q == S_HALT);

`ifdef BIP_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign o_illegal = illegal_q;

  always_ff @(posedge i_clock) begin
    if (!i_reset) illegal_q <= 1'b0;
    else          illegal_q <= illegal_d;
  end
`endif

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    o_insmem_en = 1'b0;
    o_sel_a     = 2'b00;
    o_sel_b     = 1'b0;
    o_op        = 1'b0;
    o_wr_acc    = 1'b0;
    o_wr_ram    = 1'b0;
    o_rd_ram    = 1'b0;
`ifdef BIP_ILLEGAL_TRAP_EN
    illegal_d   = illegal_q;
`endif
    case (state_q)
      S_FETCH: begin
        o_insmem_en = 1'b1;
        state_d     = S_EXEC;
      end
      S_EXEC: begin
        pc_d    = pc_q + 1'b1;
        state_d = S_FETCH;
        case (opcode)
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          OP_STORE: o_wr_ram = 1'b1;
          OP_LDV: begin
            o_rd_ram = 1'b1;
            o_wr_acc = 1'b1;
          end
          OP_LDI: begin
            o_sel_a  = 2'b01;
            o_wr_acc = 1'b1;
          end
          OP_ADDV, OP_SUBV: begin
            o_rd_ram = 1'b1;
            o_sel_b  = 1'b1;
            o_op     = (opcode == OP_SUBV);
            o_sel_a  = 2'b10;
            o_wr_acc = 1'b1;
          end
          OP_ADDI, OP_SUBI: begin
            o_op     = (opcode == OP_SUBI);
            o_sel_a  = 2'b10;
            o_wr_acc = 1'b1;
          end
          default: begin
`ifdef BIP_ILLEGAL_TRAP_EN
            // Keep PC on the offending word so software can inspect it.
            pc_d      = pc_q;
            state_d   = S_HALT;
            illegal_d = 1'b1;
`endif
          end
        endcase
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // Program memory is disabled too, so the held instruction replays on resume.
    if (!i_enable) begin
      state_d     = state_q;
      pc_d        = pc_q;
      o_insmem_en = 1'b0;
      o_wr_acc    = 1'b0;
      o_wr_ram    = 1'b0;
      o_rd_ram    = 1'b0;
`ifdef BIP_ILLEGAL_TRAP_EN
      illegal_d   = illegal_q;
`endif
    end
  end

endmodule

// File: tb/tb_bip_control_unit.sv
// tb/tb_bip_control_unit.sv - directed scoreboard bench for bip_control_unit.
module tb_bip_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] instr = 16'h0000;
  logic [10:0] addr;
  logic        mem_en;
  logic [10:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b, op, wr_acc, wr_ram, rd_ram, halted;
`ifdef BIP_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  logic [15:0] mem [0:2047];
  logic [19:0] sb_q[$];
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          n_total = 0;

  localparam logic [19:0] STALL_MASK = 20'hF1FFF;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_en) instr <= mem[addr];

  bip_control_unit dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_enable      (en),
    .i_instruction (instr),
    .o_insmem_addr (addr),
    .o_insmem_en   (mem_en),
    .o_operand     (operand),
    .o_sel_a       (sel_a),
    .o_sel_b       (sel_b),
    .o_op          (op),
    .o_wr_acc      (wr_acc),
    .o_wr_ram      (wr_ram),
    .o_rd_ram      (rd_ram),
    .o_halted      (halted)
`ifdef BIP_ILLEGAL_TRAP_EN
    ,
    .o_illegal     (illegal)
`endif
  );

  // Packed layout: sel_a[19:18] sel_b[17] op[16] wr_acc[15] wr_ram[14] rd_ram[13] operand[12:2] en[1] halted[0]
  function automatic logic [19:0] exp_exec(input logic [15:0] ins);
    logic [1:0] sa = 2'b00;
    logic sb = 1'b0, o = 1'b0, wa = 1'b0, wr = 1'b0, rr = 1'b0;
    case (ins[15:11])
      5'd1: wr = 1'b1;
      5'd2: begin rr = 1'b1; wa = 1'b1; end
      5'd3: begin sa = 2'b01; wa = 1'b1; end
      5'd4: begin rr = 1'b1; sb = 1'b1; sa = 2'b10; wa = 1'b1; end
      5'd5: begin sa = 2'b10; wa = 1'b1; end
      5'd6: begin rr = 1'b1; sb = 1'b1; o = 1'b1; sa = 2'b10; wa = 1'b1; end
      5'd7: begin o = 1'b1; sa = 2'b10; wa = 1'b1; end
      default: ;
    endcase
    return {sa, sb, o, wa, wr, rr, ins[10:0], 1'b0, 1'b0};
  endfunction

  function automatic logic [19:0] obs();
    return {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, operand, mem_en, halted};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [10:0] a, input int stall);
    logic [19:0] e;
    chk("fetch_addr", 32'(addr), 32'(a));
    chk("fetch_ctl", {mem_en, wr_acc, wr_ram, rd_ram, halted}, 5'b10000);
    sb_q.push_back(exp_exec(mem[a]));
    tick();
    e = sb_q.pop_front();
    if (stall > 0) begin
      en = 1'b0;
      #1;
      for (int k = 0; k < stall; k++) begin
        chk("stall_out", obs(), e & STALL_MASK);
        chk("stall_addr", 32'(addr), 32'(a));
        tick();
      end
      en = 1'b1;
      #1;
    end
    chk($sformatf("exec@%0d", a), obs(), e);
    chk("exec_addr", 32'(addr), 32'(a));
    tick();
  endtask

  initial begin
    en    = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1001; mem[1] = 16'h2802; mem[2] = 16'h0807; mem[3] = 16'h1808;
    mem[4] = 16'h3002; mem[5] = 16'h2002; mem[6] = 16'h080B; mem[7] = 16'h1803;
    mem[8] = 16'h3803; mem[9] = 16'h0000;
    tick();
    tick();
    chk("rst_addr", 32'(addr), 0);
    chk("rst_ctl", {sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, mem_en, halted}, 9'b000000010);

    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) run_instr(11'(i), (i == 1) ? 3 : 0);
    for (int k = 0; k < 3; k++) begin
      chk("halted", {addr, mem_en, halted, wr_acc, wr_ram, rd_ram}, {11'd9, 1'b0, 1'b1, 3'b000});
      tick();
    end

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) run_instr(11'(i), 0);
    chk("pre_rst_pc", 32'(addr), 5);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_addr", 32'(addr), 0);
    chk("mid_rst_ctl", {mem_en, halted, wr_acc, wr_ram, rd_ram}, 5'b10000);
    rst_n = 1'b1;
    #1;
    run_instr(11'd0, 0);
    run_instr(11'd1, 0);

`ifdef BIP_ILLEGAL_TRAP_EN
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1801; mem[1] = 16'h2802; mem[2] = 16'h0807; mem[3] = 16'hF800;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("trap_rst", 32'(illegal), 0);
    for (int i = 0; i < 3; i++) run_instr(11'(i), 0);
    chk("trap_fetch", 32'(addr), 3);
    tick();
    chk("trap_exec", {wr_acc, wr_ram, rd_ram, mem_en, illegal}, 5'b00000);
    tick();
    chk("trap_state", {addr, halted, illegal, mem_en, wr_acc, wr_ram, rd_ram},
        {11'd3, 1'b1, 1'b1, 1'b0, 3'b000});
`else
    for (int i = 0; i < 2048; i++) mem[i] = 16'hF800;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    repeat (2046 * 2) tick();
    run_instr(11'd2046, 0);
    run_instr(11'd2047, 0);
    run_instr(11'd0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
